// File: rtl/reset_sequencer_pkg.sv
// Shared state encoding and default parameters for the reset sequencer.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        STAGGER   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int DEF_NUM_LOCKS      = 3;
    localparam int DEF_NUM_DOMAINS    = 3;
    localparam int DEF_HOLD_CYCLES    = 16777215;
    localparam int DEF_STAGGER_CYCLES = 256;
    localparam int DEF_SYNC_STAGES    = 2;

    localparam logic [7:0] LOSS_COUNT_MAX = 8'hFF;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Multi-flop synchronizer for one asynchronous level into the clk domain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] shift_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= {shift_reg[STAGES-2:0], d};
        end
    end

    assign q = shift_reg[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Power-on reset sequencer: waits for all clock locks, holds, then releases
// reset domains one by one with a fixed stagger; any abort restarts it.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_LOCKS      = DEF_NUM_LOCKS,
    parameter int NUM_DOMAINS    = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int STAGGER_CYCLES = DEF_STAGGER_CYCLES,
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   reset_req,
    input  logic [NUM_LOCKS-1:0]   locked,
    input  logic                   sw_reset,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   all_released,
    output logic [7:0]             loss_count
);

    localparam int CNT_MAX = max_int(HOLD_CYCLES, STAGGER_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);

    logic [NUM_LOCKS-1:0] lock_sync;
    logic                 req_sync;

    generate
        for (genvar gi = 0; gi < NUM_LOCKS; gi++) begin : g_lock_sync
            sync_bit #(.STAGES(SYNC_STAGES)) u_sync_lock (
                .clk     (clk),
                .reset_n (reset_n),
                .d       (locked[gi]),
                .q       (lock_sync[gi])
            );
        end
    endgenerate

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (reset_req),
        .q       (req_sync)
    );

    logic lock_loss;
    logic abort;

    assign lock_loss = ~(&lock_sync);
    assign abort     = req_sync | sw_reset | lock_loss;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic [NUM_DOMAINS-1:0] domain_reset_reg;
    logic                   all_released_reg;
    logic [7:0]             loss_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= WAIT_LOCK;
            cnt_reg          <= '0;
            idx_reg          <= '0;
            domain_reset_reg <= '1;
            all_released_reg <= 1'b0;
            loss_count_reg   <= '0;
        end else begin
            // Losing lock while still waiting for it is expected, not an event.
            if (abort && lock_loss && (state_reg != WAIT_LOCK) &&
                (loss_count_reg != LOSS_COUNT_MAX)) begin
                loss_count_reg <= loss_count_reg + 8'd1;
            end

            if (abort) begin
                state_reg        <= WAIT_LOCK;
                cnt_reg          <= '0;
                idx_reg          <= '0;
                domain_reset_reg <= '1;
                all_released_reg <= 1'b0;
            end else begin
                case (state_reg)
                    WAIT_LOCK: begin
                        state_reg <= HOLD;
                        cnt_reg   <= '0;
                    end
                    HOLD: begin
                        if (cnt_reg == HOLD_LAST) begin
                            cnt_reg             <= '0;
                            domain_reset_reg[0] <= 1'b0;
                            if (NUM_DOMAINS > 1) begin
                                state_reg <= STAGGER;
                                idx_reg   <= IDX_W'(1);
                            end else begin
                                state_reg        <= RUN;
                                all_released_reg <= 1'b1;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    STAGGER: begin
                        if (cnt_reg == STAGGER_LAST) begin
                            cnt_reg                   <= '0;
                            domain_reset_reg[idx_reg] <= 1'b0;
                            if (idx_reg == IDX_LAST) begin
                                state_reg        <= RUN;
                                all_released_reg <= 1'b1;
                            end else begin
                                idx_reg <= idx_reg + IDX_W'(1);
                            end
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
                    end
                    RUN: begin
                        state_reg <= RUN;
                    end
                    default: begin
                        state_reg <= WAIT_LOCK;
                    end
                endcase
            end
        end
    end

    assign domain_reset = domain_reset_reg;
    assign all_released = all_released_reg;
    assign loss_count   = loss_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed, table-driven bench for reset_sequencer with small parameters.
module tb_reset_sequencer;

    logic       clk;
    logic       reset_n;
    logic       reset_req;
    logic [2:0] locked;
    logic       sw_reset;
    logic [2:0] domain_reset;
    logic       all_released;
    logic [7:0] loss_count;

    reset_sequencer #(
        .NUM_LOCKS      (3),
        .NUM_DOMAINS    (3),
        .HOLD_CYCLES    (16),
        .STAGGER_CYCLES (4),
        .SYNC_STAGES    (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .reset_req    (reset_req),
        .locked       (locked),
        .sw_reset     (sw_reset),
        .domain_reset (domain_reset),
        .all_released (all_released),
        .loss_count   (loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         edge_no;
        logic [2:0] locked;
        logic       req;
        logic [2:0] exp_dr;
        logic       exp_ar;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic advance_to(input int e);
        while (cyc < e) tick();
    endtask

    // Full sequence relative to a base edge: HOLD entered at base+3.
    task automatic run_table(input int base, input logic [7:0] exp_lc);
        for (int i = 0; i < 8; i++) begin
            locked    = vecs[i].locked;
            reset_req = vecs[i].req;
            advance_to(base + vecs[i].edge_no);
            check("domain_reset", 32'(domain_reset), 32'(vecs[i].exp_dr));
            check("all_released", 32'(all_released), 32'(vecs[i].exp_ar));
            check("loss_count", 32'(loss_count), 32'(exp_lc));
            $display("vec %0d edge %0d: domain_reset=%b all_released=%b loss_count=%0d",
                     i, cyc, domain_reset, all_released, loss_count);
        end
    endtask

    int base;

    initial begin
        vecs[0] = '{2,  3'b111, 1'b0, 3'b111, 1'b0};
        vecs[1] = '{18, 3'b111, 1'b0, 3'b111, 1'b0};
        vecs[2] = '{19, 3'b111, 1'b0, 3'b110, 1'b0};
        vecs[3] = '{22, 3'b111, 1'b0, 3'b110, 1'b0};
        vecs[4] = '{23, 3'b111, 1'b0, 3'b100, 1'b0};
        vecs[5] = '{26, 3'b111, 1'b0, 3'b100, 1'b0};
        vecs[6] = '{27, 3'b111, 1'b0, 3'b000, 1'b1};
        vecs[7] = '{30, 3'b111, 1'b0, 3'b000, 1'b1};

        reset_n   = 1'b0;
        reset_req = 1'b0;
        locked    = 3'b111;
        sw_reset  = 1'b0;
        tick();
        tick();
        check("reset domain_reset", 32'(domain_reset), 32'h7);
        check("reset all_released", 32'(all_released), 32'h0);
        check("reset loss_count", 32'(loss_count), 32'h0);
        $display("reset: domain_reset=%b all_released=%b", domain_reset, all_released);

        // Baseline power-up sequence.
        #3 reset_n = 1'b1;
        cyc = 0;
        run_table(0, 8'd0);

        // Single-cycle lock loss from RUN.
        base = cyc;
        locked = 3'b101;
        tick();
        locked = 3'b111;
        advance_to(base + 2);
        check("lockloss before abort", 32'(domain_reset), 32'h0);
        advance_to(base + 3);
        check("lockloss abort", 32'(domain_reset), 32'h7);
        check("lockloss count", 32'(loss_count), 32'd1);
        $display("lock loss: domain_reset=%b loss_count=%0d", domain_reset, loss_count);
        run_table(base + 1, 8'd1);

        // sw_reset from RUN, then again mid-STAGGER after domain 0 release.
        base = cyc;
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("sw from run", 32'(domain_reset), 32'h7);
        base = base - 1;
        advance_to(base + 20);
        check("stagger dom0 out", 32'(domain_reset), 32'h6);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("sw in stagger dr", 32'(domain_reset), 32'h7);
        check("sw in stagger ar", 32'(all_released), 32'h0);
        check("sw in stagger lc", 32'(loss_count), 32'd1);
        $display("sw_reset in STAGGER: domain_reset=%b loss_count=%0d", domain_reset, loss_count);
        base = base + 19;

        // Abort on the exact edge that would release domain 0.
        advance_to(base + 18);
        check("pre-release", 32'(domain_reset), 32'h7);
        sw_reset = 1'b1;
        tick();
        sw_reset = 1'b0;
        check("abort beats release", 32'(domain_reset), 32'h7);
        $display("abort on release edge: domain_reset=%b", domain_reset);
        run_table(base + 17, 8'd1);

        // Long reset_req hold.
        reset_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        for (int i = 0; i < 37; i++) begin
            check("req held", 32'(domain_reset), 32'h7);
            tick();
        end
        reset_req = 1'b0;
        base = cyc;
        $display("reset_req released at edge %0d", base);
        run_table(base, 8'd1);

        // Repeated lock-loss pulses saturate the loss counter.
        for (int p = 1; p <= 300; p++) begin
            locked = 3'b110;
            tick();
            locked = 3'b111;
            tick();
            tick();
            tick();
            if (p == 1 || p == 100 || p == 254) begin
                check("loss count ramp", 32'(loss_count), 32'(p + 1));
                $display("pulse %0d: loss_count=%0d", p, loss_count);
            end
            if (p == 255 || p == 300) begin
                check("loss count sat", 32'(loss_count), 32'd255);
                $display("pulse %0d: loss_count=%0d", p, loss_count);
            end
        end

        // Asynchronous reset assertion mid-HOLD.
        for (int i = 0; i < 5; i++) tick();
        check("mid-hold dr", 32'(domain_reset), 32'h7);
        #2 reset_n = 1'b0;
        #1;
        check("async dr", 32'(domain_reset), 32'h7);
        check("async ar", 32'(all_released), 32'h0);
        check("async lc", 32'(loss_count), 32'h0);
        $display("async reset: domain_reset=%b loss_count=%0d", domain_reset, loss_count);
        tick();
        tick();
        #3 reset_n = 1'b1;
        cyc = 0;
        run_table(0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
